// File: rtl/rvx_bus_arbiter_pkg.sv
// Shared constants and types for the rvx bus arbiter.
// The optional timeout path is enabled with RVX_BUS_ARBITER_TIMEOUT_EN.
package rvx_bus_arbiter_pkg;

    localparam int          TMO_W     = 8;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    // Data-side request as captured in IDLE; is_write selects the memory strobe.
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] wdata;
        logic [3:0]  wstrobe;
        logic        is_write;
    } bus_req_t;

endpackage

// File: rtl/rvx_bus_timeout.sv
// Wait-state watchdog for the rvx bus arbiter; instantiated only when
// RVX_BUS_ARBITER_TIMEOUT_EN is defined.
module rvx_bus_timeout
    import rvx_bus_arbiter_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in_wait,
    input  logic ack,
    output logic expired
);

    logic [TMO_W-1:0] count;

    // Expires on the edge where the count would reach TIMEOUT_CYCLES, so the
    // WAIT state lasts exactly TIMEOUT_CYCLES cycles before forced completion.
    assign expired = in_wait && !ack && ((count + 1'b1) == TIMEOUT_CYCLES);

    // Any completion also clears the count, which doubles as the clear on
    // entry into the following WAIT state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!in_wait || ack || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rvx_bus_arbiter.sv
// Round-based arbiter sharing one memory port between the instruction and data
// buses. Optional timeout: define RVX_BUS_ARBITER_TIMEOUT_EN.
module rvx_bus_arbiter
    import rvx_bus_arbiter_pkg::*;
#(
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ibus_address,
    input  logic        ibus_rrequest,
    output logic [31:0] ibus_rdata,
    output logic        ibus_rresponse,
    input  logic [31:0] dbus_address,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    input  logic        dbus_rrequest,
    input  logic        dbus_wrequest,
    output logic [31:0] dbus_rdata,
    output logic        dbus_rresponse,
    output logic        dbus_wresponse,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrobe,
    output logic        mem_rrequest,
    output logic        mem_wrequest,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresponse,
    input  logic        mem_wresponse,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_WAIT  = 2'd1,
        I_WAIT  = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        pend_d;
    logic        pend_i;
    bus_req_t    d_req;
    logic [31:0] i_addr;
    logic [31:0] d_buf;
    logic [31:0] i_buf;
    logic        mem_ack;
    logic        tmo_expired;
    logic        done;
    logic [31:0] rdata_in;

    // Only the response matching the current WAIT state's access counts.
    always_comb begin
        mem_ack = 1'b0;
        case (state)
            D_WAIT:  mem_ack = d_req.is_write ? mem_wresponse : mem_rresponse;
            I_WAIT:  mem_ack = mem_rresponse;
            default: mem_ack = 1'b0;
        endcase
    end

    assign done     = mem_ack || tmo_expired;
    assign rdata_in = mem_ack ? mem_rdata : ZERO_WORD;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            pend_d <= 1'b0;
            pend_i <= 1'b0;
            d_req  <= '0;
            i_addr <= ZERO_WORD;
            d_buf  <= ZERO_WORD;
            i_buf  <= ZERO_WORD;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                pend_d         <= dbus_rrequest || dbus_wrequest;
                pend_i         <= ibus_rrequest;
                d_req.address  <= dbus_address;
                d_req.wdata    <= dbus_wdata;
                d_req.wstrobe  <= dbus_wstrobe;
                d_req.is_write <= dbus_wrequest;
                i_addr         <= ibus_address;
            end
            if (state == D_WAIT && done && !d_req.is_write) begin
                d_buf <= rdata_in;
            end
            if (state == I_WAIT && done) begin
                i_buf <= rdata_in;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        mem_address    = ZERO_WORD;
        mem_wdata      = ZERO_WORD;
        mem_wstrobe    = 4'b0000;
        mem_rrequest   = 1'b0;
        mem_wrequest   = 1'b0;
        ibus_rresponse = 1'b0;
        dbus_rresponse = 1'b0;
        dbus_wresponse = 1'b0;
        case (state)
            IDLE: begin
                if (dbus_rrequest || dbus_wrequest) begin
                    state_nxt = D_WAIT;
                end else if (ibus_rrequest) begin
                    state_nxt = I_WAIT;
                end
            end
            D_WAIT: begin
                mem_address  = d_req.address;
                mem_wdata    = d_req.wdata;
                mem_wstrobe  = d_req.wstrobe;
                mem_wrequest = d_req.is_write;
                mem_rrequest = !d_req.is_write;
                if (done) begin
                    state_nxt = pend_i ? I_WAIT : RESPOND;
                end
            end
            I_WAIT: begin
                mem_address  = i_addr;
                mem_rrequest = 1'b1;
                if (done) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                // Every response of the round fires together so a stalled core resumes once.
                ibus_rresponse = pend_i;
                dbus_rresponse = pend_d && !d_req.is_write;
                dbus_wresponse = pend_d && d_req.is_write;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ibus_rdata = i_buf;
    assign dbus_rdata = d_buf;

`ifdef RVX_BUS_ARBITER_TIMEOUT_EN
    logic in_wait;
    logic round_err;

    assign in_wait = (state == D_WAIT) || (state == I_WAIT);

    rvx_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .in_wait (in_wait),
        .ack     (mem_ack),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            round_err <= 1'b0;
        end else if (state == IDLE) begin
            round_err <= 1'b0;
        end else if (tmo_expired) begin
            round_err <= 1'b1;
        end
    end

    assign bus_error = (state == RESPOND) && round_err;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_expired        = 1'b0;
    assign bus_error          = 1'b0;
`endif

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Directed self-checking bench for rvx_bus_arbiter with a wait-state memory model.
// Timeout vectors run only when RVX_BUS_ARBITER_TIMEOUT_EN is defined.
module tb_rvx_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] ibus_address;
    logic        ibus_rrequest;
    logic [31:0] ibus_rdata;
    logic        ibus_rresponse;
    logic [31:0] dbus_address;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrobe;
    logic        dbus_rrequest;
    logic        dbus_wrequest;
    logic [31:0] dbus_rdata;
    logic        dbus_rresponse;
    logic        dbus_wresponse;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrobe;
    logic        mem_rrequest;
    logic        mem_wrequest;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_rresponse = 1'b0;
    logic        mem_wresponse = 1'b0;
    logic        bus_error;

    always #5 clock = ~clock;

    rvx_bus_arbiter #(
        .TIMEOUT_CYCLES(8'd4)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ibus_address   (ibus_address),
        .ibus_rrequest  (ibus_rrequest),
        .ibus_rdata     (ibus_rdata),
        .ibus_rresponse (ibus_rresponse),
        .dbus_address   (dbus_address),
        .dbus_wdata     (dbus_wdata),
        .dbus_wstrobe   (dbus_wstrobe),
        .dbus_rrequest  (dbus_rrequest),
        .dbus_wrequest  (dbus_wrequest),
        .dbus_rdata     (dbus_rdata),
        .dbus_rresponse (dbus_rresponse),
        .dbus_wresponse (dbus_wresponse),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_wstrobe    (mem_wstrobe),
        .mem_rrequest   (mem_rrequest),
        .mem_wrequest   (mem_wrequest),
        .mem_rdata      (mem_rdata),
        .mem_rresponse  (mem_rresponse),
        .mem_wresponse  (mem_wresponse),
        .bus_error      (bus_error)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory model: responds after mem_wait stalled cycles; mem_dead never responds.
    int          mem_wait = 0;
    bit          mem_dead = 1'b0;
    bit          stray    = 1'b0;
    int          wcnt     = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_strb[$];
    logic [31:0] log_wr[$];
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_2000: return 32'hD00D_2000;
            default:       return a ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(negedge clock) begin
        mem_rresponse = 1'b0;
        mem_wresponse = 1'b0;
        mem_rdata     = 32'h0;
        if (mem_rrequest || mem_wrequest) begin
            if (!mem_dead && wcnt >= mem_wait) begin
                if (mem_wrequest) begin
                    mem_wresponse = 1'b1;
                end else begin
                    mem_rresponse = 1'b1;
                    mem_rdata     = mem_word(mem_address);
                end
                log_addr.push_back(mem_address);
                log_wdata.push_back(mem_wdata);
                log_strb.push_back(mem_wstrobe);
                log_wr.push_back({31'd0, mem_wrequest});
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (stray) begin
                mem_rresponse = 1'b1;
                mem_wresponse = 1'b1;
                mem_rdata     = 32'hBAD0_BAD0;
            end
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic drop_requests();
        ibus_rrequest = 1'b0;
        dbus_rrequest = 1'b0;
        dbus_wrequest = 1'b0;
    endtask

    task automatic release_round();
        sync();
        drop_requests();
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_wdata.delete();
        log_strb.delete();
        log_wr.delete();
    endtask

    // Latency in cycles from the request cycle to the response cycle; -1 on a missing response.
    task automatic wait_resp(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (ibus_rresponse || dbus_rresponse || dbus_wresponse) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic dbus_read(input logic [31:0] a);
        dbus_address  = a;
        dbus_rrequest = 1'b1;
    endtask

    logic [31:0] rd_addrs[3] = '{32'h0000_2000, 32'h0000_0A0C, 32'h0000_7FF0};
    int          rd_waits[3] = '{1, 0, 3};

    initial begin
        int lat;
        int resp_seen;

        reset_n      = 1'b0;
        ibus_address = 32'h0;
        dbus_address = 32'h0;
        dbus_wdata   = 32'h0;
        dbus_wstrobe = 4'h0;
        drop_requests();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_mem_rreq", mem_rrequest, 1'b0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_ibus_resp", ibus_rresponse, 1'b0);
        check("rst_ibus_rdata", ibus_rdata, 32'h0);
        check("rst_bus_error", bus_error, 1'b0);
        sync();
        reset_n = 1'b1;

        // Single instruction fetch, zero-wait memory.
        ibus_address  = 32'h0000_0100;
        ibus_rrequest = 1'b1;
        @(negedge clock);
        check("t0_mem_rreq", mem_rrequest, 1'b0);
        @(negedge clock);
        check("t1_mem_rreq", mem_rrequest, 1'b1);
        check("t1_mem_addr", mem_address, 32'h0000_0100);
        check("t1_mem_wreq", mem_wrequest, 1'b0);
        @(negedge clock);
        check("t2_ibus_resp", ibus_rresponse, 1'b1);
        check("t2_ibus_rdata", ibus_rdata, 32'h0000_0013);
        check("t2_dbus_resp", dbus_rresponse, 1'b0);
        check("t2_bus_error", bus_error, 1'b0);
        release_round();
        @(negedge clock);
        check("t3_ibus_resp", ibus_rresponse, 1'b0);
        check("t3_ibus_hold", ibus_rdata, 32'h0000_0013);
        check("t3_mem_rreq", mem_rrequest, 1'b0);
        check("t3_mem_addr", mem_address, 32'h0);

        // Dual read, two wait states: data first, then instruction, one response cycle.
        mem_wait = 2;
        clear_log();
        sync();
        ibus_address  = 32'h0000_0100;
        ibus_rrequest = 1'b1;
        dbus_read(32'h0000_2000);
        wait_resp(lat);
        check("dual_latency", lat, 32'd7);
        check("dual_ibus_resp", ibus_rresponse, 1'b1);
        check("dual_dbus_resp", dbus_rresponse, 1'b1);
        check("dual_dbus_wresp", dbus_wresponse, 1'b0);
        check("dual_ibus_rdata", ibus_rdata, 32'h0000_0013);
        check("dual_dbus_rdata", dbus_rdata, 32'hD00D_2000);
        check("dual_bus_error", bus_error, 1'b0);
        release_round();
        exp_q = '{32'h0000_2000, 32'h0000_0100};
        check("dual_mem_count", log_addr.size(), exp_q.size());
        while (exp_q.size() > 0 && log_addr.size() > 0) begin
            check("dual_mem_order", log_addr.pop_front(), exp_q.pop_front());
        end

        // Write plus fetch: write goes out first with exact data and strobes.
        mem_wait = 0;
        clear_log();
        sync();
        dbus_address  = 32'h0000_3000;
        dbus_wdata    = 32'hCAFE_BABE;
        dbus_wstrobe  = 4'b0011;
        dbus_wrequest = 1'b1;
        ibus_address  = 32'h0000_0100;
        ibus_rrequest = 1'b1;
        wait_resp(lat);
        check("wr_latency", lat, 32'd3);
        check("wr_dbus_wresp", dbus_wresponse, 1'b1);
        check("wr_ibus_resp", ibus_rresponse, 1'b1);
        check("wr_dbus_rresp", dbus_rresponse, 1'b0);
        check("wr_ibus_rdata", ibus_rdata, 32'h0000_0013);
        release_round();
        check("wr_mem_count", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            check("wr_first_kind", log_wr[0], 32'd1);
            check("wr_first_addr", log_addr[0], 32'h0000_3000);
            check("wr_first_wdata", log_wdata[0], 32'hCAFE_BABE);
            check("wr_first_strb", {28'd0, log_strb[0]}, 32'h3);
            check("wr_second_kind", log_wr[1], 32'd0);
            check("wr_second_addr", log_addr[1], 32'h0000_0100);
        end

        // Read and write both requested: the write wins, the read is dropped.
        clear_log();
        sync();
        dbus_address  = 32'h0000_4000;
        dbus_wdata    = 32'h1122_3344;
        dbus_wstrobe  = 4'b1111;
        dbus_wrequest = 1'b1;
        dbus_rrequest = 1'b1;
        wait_resp(lat);
        check("rw_latency", lat, 32'd2);
        check("rw_dbus_wresp", dbus_wresponse, 1'b1);
        check("rw_dbus_rresp", dbus_rresponse, 1'b0);
        check("rw_ibus_resp", ibus_rresponse, 1'b0);
        release_round();
        check("rw_mem_count", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            check("rw_mem_kind", log_wr[0], 32'd1);
        end
        @(negedge clock);
        check("idle_mem_wdata", mem_wdata, 32'h0);
        check("idle_mem_strb", {28'd0, mem_wstrobe}, 32'h0);
        check("idle_mem_wreq", mem_wrequest, 1'b0);

        // Stray memory response while idle must be ignored.
        clear_log();
        sync();
        stray = 1'b1;
        sync();
        stray = 1'b0;
        @(negedge clock);
        check("stray_ibus_resp", ibus_rresponse, 1'b0);
        check("stray_dbus_resp", dbus_rresponse, 1'b0);
        check("stray_dbus_wresp", dbus_wresponse, 1'b0);
        check("stray_mem_rreq", mem_rrequest, 1'b0);
        check("stray_dbus_hold", dbus_rdata, 32'hD00D_2000);

        // Data reads over a table of addresses and wait states.
        for (int v = 0; v < 3; v++) begin
            mem_wait = rd_waits[v];
            sync();
            dbus_read(rd_addrs[v]);
            wait_resp(lat);
            check("tbl_latency", lat, 32'(2 + rd_waits[v]));
            check("tbl_dbus_resp", dbus_rresponse, 1'b1);
            check("tbl_dbus_rdata", dbus_rdata, mem_word(rd_addrs[v]));
            release_round();
        end
        mem_wait = 0;

`ifdef RVX_BUS_ARBITER_TIMEOUT_EN
        // Memory never answers: forced completion after four wait cycles.
        mem_dead = 1'b1;
        sync();
        ibus_address  = 32'h0000_0104;
        ibus_rrequest = 1'b1;
        wait_resp(lat);
        check("tmo_latency", lat, 32'd5);
        check("tmo_ibus_resp", ibus_rresponse, 1'b1);
        check("tmo_ibus_rdata", ibus_rdata, 32'h0);
        check("tmo_bus_error", bus_error, 1'b1);
        release_round();
        @(negedge clock);
        check("tmo_err_pulse", bus_error, 1'b0);
        check("tmo_idle_rreq", mem_rrequest, 1'b0);
        mem_dead = 1'b0;
`endif

        // Reset in the middle of a data wait.
        mem_dead = 1'b1;
        sync();
        dbus_read(32'h0000_5000);
        @(negedge clock);
        @(negedge clock);
        check("mid_mem_rreq", mem_rrequest, 1'b1);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_rreq", mem_rrequest, 1'b0);
        check("mid_rst_addr", mem_address, 32'h0);
        check("mid_rst_dresp", dbus_rresponse, 1'b0);
        check("mid_rst_drdata", dbus_rdata, 32'h0);
        check("mid_rst_irdata", ibus_rdata, 32'h0);
        check("mid_rst_error", bus_error, 1'b0);
        drop_requests();
        mem_dead = 1'b0;
        sync();
        reset_n = 1'b1;
        resp_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (ibus_rresponse || dbus_rresponse || dbus_wresponse) resp_seen++;
        end
        check("post_rst_quiet", resp_seen, 32'd0);
        sync();
        dbus_read(32'h0000_2000);
        wait_resp(lat);
        check("post_rst_latency", lat, 32'd2);
        check("post_rst_rdata", dbus_rdata, 32'hD00D_2000);
        release_round();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
